// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, read handshake and status outputs of the 8N1 UART receiver
interface uart_rx_if;
  logic       i_rx;
  logic       i_rd_ack;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_data_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
  modport slave (
    input  i_rx, i_rd_ack,
    output o_data, o_data_valid, o_data_ready, o_frame_err, o_overrun, o_busy
  );
  modport master (
    output i_rx, i_rd_ack,
    input  o_data, o_data_valid, o_data_ready, o_frame_err, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, framing-error and overrun reporting
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ready;
  logic          r_ferr;
  logic          r_ovr;
  logic          w_rx_s;
  logic          w_half;
  logic          w_full;
  assign w_rx_s = r_sync[1];
  assign w_half = r_cnt == HALF_LAST;
  assign w_full = r_cnt == BIT_LAST;
  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_valid;
  assign bus.o_data_ready = r_ready;
  assign bus.o_frame_err  = r_ferr;
  assign bus.o_overrun    = r_ovr;
  assign bus.o_busy       = r_state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.i_rx};
      r_cnt   <= r_cnt + CW'(1);
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (bus.i_rd_ack) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= START;
        end
        START: if (w_half) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx_s ? IDLE : DATA;
        end
        DATA: if (w_full) begin
          r_cnt   <= '0;
          r_shreg <= {w_rx_s, r_shreg[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= STOP;
        end
        STOP: if (w_full) begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_data  <= r_shreg;
            r_valid <= 1'b1;
            r_ready <= 1'b1;
            if (r_ready && !bus.i_rd_ack) r_ovr <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_ferr  <= 1'b1;
            r_state <= BRK;
          end
        end
        // a line held low after a bad stop bit must not look like a new start bit
        BRK: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames checked against a frame-level model of the receiver
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if u_if();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(u_if));
  always #5 clk = ~clk;
  int n_assert, n_fail, cyc, vhigh, vrise, ferr_cnt, bad_busy, fstart, lat;
  int vcyc[$];
  logic prev_v = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] m_data, rb;
  logic m_ready, m_ovr;
  int m_good, m_ferr;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (u_if.o_data_valid) begin
      vhigh++;
      if (!prev_v) begin
        vrise++;
        vcyc.push_back(cyc);
      end
      if (u_if.o_busy || !prev_busy) bad_busy++;
    end
    if (u_if.o_frame_err) ferr_cnt++;
    prev_v = u_if.o_data_valid;
    prev_busy = u_if.o_busy;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    u_if.i_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ack();
    u_if.i_rd_ack = 1'b1;
    @(posedge clk);
    #1;
    u_if.i_rd_ack = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic ack_start, input logic ack_stop);
    fstart = cyc;
    u_if.i_rx = 1'b0;
    u_if.i_rd_ack = ack_start;
    @(posedge clk);
    #1;
    u_if.i_rd_ack = 1'b0;
    repeat (CPB - 1) @(posedge clk);
    #1;
    if (ack_start) begin
      m_ready = 1'b0;
      m_ovr = 1'b0;
    end
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (ack_stop) begin
      hold(stop, 10);
      u_if.i_rd_ack = 1'b1;
      hold(stop, 1);
      u_if.i_rd_ack = 1'b0;
      hold(stop, CPB - 11);
    end else hold(stop, CPB);
    if (stop) begin
      m_ovr = ack_stop ? 1'b0 : (m_ovr | m_ready);
      m_ready = 1'b1;
      m_data = b;
      m_good++;
    end else m_ferr++;
  endtask
  task automatic check_state(input string tag);
    chk({tag, ".data"}, u_if.o_data, m_data);
    chk({tag, ".ready"}, u_if.o_data_ready, m_ready);
    chk({tag, ".overrun"}, u_if.o_overrun, m_ovr);
    chk({tag, ".strobes"}, vrise, m_good);
    chk({tag, ".valid_cycles"}, vhigh, m_good);
    chk({tag, ".frame_errs"}, ferr_cnt, m_ferr);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, ".data"}, u_if.o_data, 8'h00);
    chk({tag, ".valid"}, u_if.o_data_valid, 1'b0);
    chk({tag, ".ready"}, u_if.o_data_ready, 1'b0);
    chk({tag, ".ferr"}, u_if.o_frame_err, 1'b0);
    chk({tag, ".overrun"}, u_if.o_overrun, 1'b0);
    chk({tag, ".busy"}, u_if.o_busy, 1'b0);
  endtask
  initial begin
    u_if.i_rx = 1'b1;
    u_if.i_rd_ack = 1'b0;
    m_data = 8'h00;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    hold(1'b1, 10);
    send(8'h55, 1'b1, 1'b0, 1'b0);
    check_state("byte55");
    lat = vcyc[vcyc.size() - 1] - fstart;
    chk("byte55.latency", (lat == 154) || (lat == 155), 1'b1);
    chk("byte55.busy", u_if.o_busy, 1'b0);
    ack();
    send(8'hA3, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b1, 1'b0);
    check_state("b2b");
    chk("b2b.spacing", vcyc[vcyc.size() - 1] - vcyc[vcyc.size() - 2], 160);
    ack();
    rb = 8'($urandom);
    send(rb, 1'b1, 1'b0, 1'b0);
    rb = 8'($urandom);
    send(rb, 1'b1, 1'b0, 1'b0);
    check_state("overrun");
    ack();
    check_state("overrun_ack");
    hold(1'b0, 5);
    hold(1'b1, 20);
    check_state("glitch");
    chk("glitch.busy", u_if.o_busy, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 40);
    chk("break.busy_low", u_if.o_busy, 1'b1);
    check_state("break");
    hold(1'b1, 10);
    chk("break.busy_idle", u_if.o_busy, 1'b0);
    send(8'h81, 1'b1, 1'b0, 1'b0);
    check_state("after_break");
    rb = 8'($urandom);
    send(rb, 1'b1, 1'b0, 1'b1);
    check_state("ack_on_store");
    rb = 8'h7E;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(rb[i], CPB);
    hold(rb[4], 8);
    rst = 1'b1;
    hold(1'b1, 3);
    check_reset("mid_reset");
    rst = 1'b0;
    m_data = 8'h00;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    hold(1'b1, 10);
    check_reset("post_reset");
    check_state("post_reset_model");
    send(8'h7E, 1'b1, 1'b0, 1'b0);
    check_state("byte7E");
    for (int k = 0; k < 6; k++) begin
      int gap;
      gap = int'($urandom_range(0, 10));
      if (gap > 0) hold(1'b1, gap);
      rb = 8'($urandom);
      send(rb, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check_state($sformatf("rand%0d", k));
    end
    chk("busy_with_strobe", bad_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
